waveform_stream_loader: RTL and testbench

Initiator-side writer for the `waveform_stream` buffer. On a start pulse it latches a waveform descriptor and issues `init_wf_write` with a packed 128-bit `waveform_parameters` word. It waits for `wf_write_ready`, then forwards exactly N 32-bit samples from a source stream (e.g. packed `CHIRP_DDS` I/Q) onto the `wfin_axis` AXI4-Stream port, marking the last beat with `tlast`. It sits between the sample generator and `waveform_stream`, in the `waveform_stream` clock domain.

---
 rtl/waveform_stream_loader.sv | 134 +++++++++++++
 tb/tb_waveform_stream_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_stream_loader.sv
// Initiator-side writer for the waveform_stream buffer: issues the init request
// with a packed descriptor, then forwards exactly N source beats with tlast on the final one.
module waveform_stream_loader #(
  parameter int DATA_W = 32
) (
  input  logic                clk_in1,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         cfg_num_words,
  input  logic [31:0]         cfg_wf_id,
  input  logic [31:0]         cfg_start_addr,
  output logic [127:0]        waveform_parameters,
  output logic                init_wf_write,
  input  logic                wf_write_ready,
  input  logic [DATA_W-1:0]   src_axis_tdata,
  input  logic                src_axis_tvalid,
  output logic                src_axis_tready,
  output logic [DATA_W-1:0]   wfin_axis_tdata,
  output logic                wfin_axis_tvalid,
  output logic                wfin_axis_tlast,
  output logic [DATA_W/8-1:0] wfin_axis_tkeep,
  input  logic                wfin_axis_tready,
  output logic                busy,
  output logic                done,
  output logic                err_start
);

  typedef enum logic [1:0] {IDLE, INIT, STREAM, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         remaining_reg, remaining_next;
  logic [127:0]        params_reg, params_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                valid_reg, valid_next;
  logic                last_reg, last_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                src_hs;
  logic                out_hs;

  // Source is only pulled while beats remain and the output stage can take one.
  assign src_axis_tready = (state_reg == STREAM) && (remaining_reg != 32'd0) &&
                           (!valid_reg || wfin_axis_tready);
  assign src_hs = src_axis_tvalid && src_axis_tready;
  assign out_hs = valid_reg && wfin_axis_tready;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    params_next    = params_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    last_next      = last_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (cfg_num_words == 32'd0) begin
            err_next = 1'b1;
          end else begin
            params_next    = {32'd0, cfg_start_addr, cfg_wf_id, cfg_num_words};
            remaining_next = cfg_num_words;
            state_next     = INIT;
          end
        end
      end
      INIT: begin
        err_next = start;
        if (wf_write_ready) state_next = STREAM;
      end
      STREAM: begin
        err_next = start;
        if (out_hs) valid_next = 1'b0;
        if (src_hs) begin
          data_next      = src_axis_tdata;
          valid_next     = 1'b1;
          last_next      = (remaining_reg == 32'd1);
          remaining_next = remaining_reg - 32'd1;
          if (remaining_reg == 32'd1) state_next = FLUSH;
        end
      end
      FLUSH: begin
        err_next = start;
        if (out_hs) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= 32'd0;
      params_reg    <= 128'd0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      params_reg    <= params_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign waveform_parameters = params_reg;
  assign init_wf_write       = (state_reg == INIT);
  assign busy                = (state_reg != IDLE);
  assign done                = done_reg;
  assign err_start           = err_reg;
  assign wfin_axis_tdata     = data_reg;
  assign wfin_axis_tvalid    = valid_reg;
  assign wfin_axis_tlast     = last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_keep
      assign wfin_axis_tkeep[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_waveform_stream_loader.sv
// Directed bench for waveform_stream_loader: descriptor latch, streaming, backpressure,
// rejected starts, back-to-back loads and asynchronous reset mid-stream.
module tb_waveform_stream_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  cfg_num_words = '0;
  logic [31:0]  cfg_wf_id = '0;
  logic [31:0]  cfg_start_addr = '0;
  logic [127:0] waveform_parameters;
  logic         init_wf_write;
  logic         wf_write_ready = 1'b0;
  logic [31:0]  src_axis_tdata = '0;
  logic         src_axis_tvalid = 1'b0;
  logic         src_axis_tready;
  logic [31:0]  wfin_axis_tdata;
  logic         wfin_axis_tvalid;
  logic         wfin_axis_tlast;
  logic [3:0]   wfin_axis_tkeep;
  logic         wfin_axis_tready = 1'b0;
  logic         busy;
  logic         done;
  logic         err_start;

  int tests = 0;
  int fails = 0;
  int src_cnt = 0;
  bit src_pend = 0;

  waveform_stream_loader #(.DATA_W(32)) dut (
    .clk_in1(clk), .reset(reset), .start(start),
    .cfg_num_words(cfg_num_words), .cfg_wf_id(cfg_wf_id), .cfg_start_addr(cfg_start_addr),
    .waveform_parameters(waveform_parameters), .init_wf_write(init_wf_write),
    .wf_write_ready(wf_write_ready),
    .src_axis_tdata(src_axis_tdata), .src_axis_tvalid(src_axis_tvalid),
    .src_axis_tready(src_axis_tready),
    .wfin_axis_tdata(wfin_axis_tdata), .wfin_axis_tvalid(wfin_axis_tvalid),
    .wfin_axis_tlast(wfin_axis_tlast), .wfin_axis_tkeep(wfin_axis_tkeep),
    .wfin_axis_tready(wfin_axis_tready),
    .busy(busy), .done(done), .err_start(err_start)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Issue a start (cfg held for one edge) then a one-cycle wf_write_ready after 'delay' cycles.
  task automatic launch(input logic [31:0] n, input logic [31:0] id, input logic [31:0] addr,
                        input int delay);
    @(negedge clk);
    start = 1'b1; cfg_num_words = n; cfg_wf_id = id; cfg_start_addr = addr;
    @(negedge clk);
    start = 1'b0;
    repeat (delay) @(negedge clk);
    wf_write_ready = 1'b1;
    @(negedge clk);
    wf_write_ready = 1'b0;
  endtask

  // Counting source plus sink; returns observed statistics of one stream.
  task automatic collect(input int n, input bit bp, input int budget, input int stop_after,
                         input int inj_cycle,
                         output int beats, output int bad_data, output int bad_last,
                         output int unstable, output int src_acc, output int err_seen,
                         output bit done_ok);
    logic [31:0] base, pd;
    logic        pl;
    logic [3:0]  pk;
    bit          stall, fin;
    beats = 0; bad_data = 0; bad_last = 0; unstable = 0; src_acc = 0; err_seen = 0;
    done_ok = 0; stall = 0; fin = 0; pd = '0; pl = 1'b0; pk = '0;
    if (src_pend) begin src_cnt++; src_pend = 0; end
    src_axis_tdata = src_cnt;
    src_axis_tvalid = 1'b1;
    base = src_cnt;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (src_pend) begin src_cnt++; src_axis_tdata = src_cnt; src_pend = 0; end
        if (err_start === 1'b1) err_seen++;
        if (stall && (wfin_axis_tvalid !== 1'b1 || wfin_axis_tdata !== pd ||
                      wfin_axis_tlast !== pl || wfin_axis_tkeep !== pk)) unstable++;
      end
      start = (cyc == inj_cycle);
      if (cyc == inj_cycle) begin
        cfg_num_words = 32'd5; cfg_wf_id = 32'hdead; cfg_start_addr = 32'hbeef;
      end
      wfin_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      stall = wfin_axis_tvalid && !wfin_axis_tready;
      pd = wfin_axis_tdata; pl = wfin_axis_tlast; pk = wfin_axis_tkeep;
      if (src_axis_tvalid && src_axis_tready) begin src_acc++; src_pend = 1; end
      if (wfin_axis_tvalid && wfin_axis_tready) begin
        if (wfin_axis_tdata !== base + 32'(beats)) bad_data++;
        if (wfin_axis_tkeep !== 4'hF) bad_data++;
        if (wfin_axis_tlast !== (beats == n - 1)) bad_last++;
        beats++;
        if (wfin_axis_tlast === 1'b1 || beats == stop_after) fin = 1;
      end
    end
    start = 1'b0;
    if (fin && stop_after == 0) begin
      @(negedge clk);
      if (src_pend) begin src_cnt++; src_axis_tdata = src_cnt; src_pend = 0; end
      done_ok = (done === 1'b1) && (busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({init_wf_write, busy, done, err_start} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {init_wf_write, busy, done, err_start});
    end
    tests++;
    if ({wfin_axis_tvalid, wfin_axis_tlast, src_axis_tready} !== 3'b000) begin
      fails++; $display("FAIL reset_axis: got %b expected 000", {wfin_axis_tvalid, wfin_axis_tlast, src_axis_tready});
    end
    tests++;
    if (wfin_axis_tkeep !== 4'h0 || wfin_axis_tdata !== 32'h0) begin
      fails++; $display("FAIL reset_data: got keep=%h data=%h expected 0/0", wfin_axis_tkeep, wfin_axis_tdata);
    end
    tests++;
    if (waveform_parameters !== 128'h0) begin
      fails++; $display("FAIL reset_params: got %h expected 0", waveform_parameters);
    end
    reset = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_load();
    int beats, bd, bl, us, sa, es;
    bit dk;
    src_cnt = 0; src_pend = 0; src_axis_tdata = 0;
    @(negedge clk);
    start = 1'b1; cfg_num_words = 32'h80; cfg_wf_id = 32'd1; cfg_start_addr = 32'h600;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || init_wf_write !== 1'b1) begin
      fails++; $display("FAIL basic_init: got busy=%b init=%b expected 1/1", busy, init_wf_write);
    end
    tests++;
    if (waveform_parameters !== {32'd0, 32'h600, 32'd1, 32'h80}) begin
      fails++; $display("FAIL basic_params: got %h expected 0..0600_00000001_00000080", waveform_parameters);
    end
    repeat (2) @(negedge clk);
    wf_write_ready = 1'b1;
    tests++;
    if (src_axis_tready !== 1'b0 || init_wf_write !== 1'b1) begin
      fails++; $display("FAIL basic_wait: got src_tready=%b init=%b expected 0/1", src_axis_tready, init_wf_write);
    end
    @(negedge clk);
    wf_write_ready = 1'b0;
    tests++;
    if (init_wf_write !== 1'b0) begin
      fails++; $display("FAIL basic_init_drop: got %b expected 0", init_wf_write);
    end
    collect(128, 0, 400, 0, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 128 || sa !== 128) begin
      fails++; $display("FAIL basic_count: got beats=%0d src=%0d expected 128/128", beats, sa);
    end
    tests++;
    if (bd !== 0 || bl !== 0) begin
      fails++; $display("FAIL basic_data: got bad_data=%0d bad_last=%0d expected 0/0", bd, bl);
    end
    tests++;
    if (dk !== 1'b1) begin
      fails++; $display("FAIL basic_done: got %b expected done=1 busy=0 after last", dk);
    end
    $display("[TB] basic load: %0d beats", beats);
  endtask

  task automatic test_backpressure();
    int beats, bd, bl, us, sa, es;
    bit dk;
    launch(32'd16, 32'd3, 32'h40, 0);
    collect(16, 1, 300, 0, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 16 || sa !== 16) begin
      fails++; $display("FAIL bp_count: got beats=%0d src=%0d expected 16/16", beats, sa);
    end
    tests++;
    if (bd !== 0 || bl !== 0) begin
      fails++; $display("FAIL bp_data: got bad_data=%0d bad_last=%0d expected 0/0", bd, bl);
    end
    tests++;
    if (us !== 0) begin
      fails++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", us);
    end
    tests++;
    if (dk !== 1'b1) begin
      fails++; $display("FAIL bp_done: got %b expected 1", dk);
    end
    $display("[TB] backpressure: %0d beats", beats);
  endtask

  task automatic test_rejected();
    int beats, bd, bl, us, sa, es;
    bit dk;
    @(negedge clk);
    start = 1'b1; cfg_num_words = 32'd0; cfg_wf_id = 32'd9; cfg_start_addr = 32'h999;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (err_start !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rej_zero: got err=%b busy=%b expected 1/0", err_start, busy);
    end
    tests++;
    if (waveform_parameters !== {32'd0, 32'h40, 32'd3, 32'd16}) begin
      fails++; $display("FAIL rej_params: got %h expected previous descriptor", waveform_parameters);
    end
    @(negedge clk);
    tests++;
    if (err_start !== 1'b0) begin
      fails++; $display("FAIL rej_pulse: got %b expected 0", err_start);
    end
    launch(32'd8, 32'd2, 32'h100, 1);
    collect(8, 0, 100, 0, 2, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (es !== 1) begin
      fails++; $display("FAIL rej_busy: got %0d err pulses expected 1", es);
    end
    tests++;
    if (beats !== 8 || bd !== 0 || bl !== 0 || dk !== 1'b1) begin
      fails++; $display("FAIL rej_stream: got beats=%0d bd=%0d bl=%0d done=%b expected 8/0/0/1", beats, bd, bl, dk);
    end
    tests++;
    if (waveform_parameters !== {32'd0, 32'h100, 32'd2, 32'd8}) begin
      fails++; $display("FAIL rej_busy_params: got %h expected 0..0100_00000002_00000008", waveform_parameters);
    end
    $display("[TB] rejected starts: %0d err pulses during stream", es);
  endtask

  task automatic test_back_to_back();
    int beats, bd, bl, us, sa, es;
    bit dk;
    launch(32'd1, 32'd4, 32'h10, 0);
    collect(1, 0, 50, 0, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 1 || bl !== 0 || bd !== 0 || dk !== 1'b1) begin
      fails++; $display("FAIL b2b_single: got beats=%0d bl=%0d bd=%0d done=%b expected 1/0/0/1", beats, bl, bd, dk);
    end
    start = 1'b1; cfg_num_words = 32'd4; cfg_wf_id = 32'd5; cfg_start_addr = 32'h20;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || init_wf_write !== 1'b1 || err_start !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: got busy=%b init=%b err=%b expected 1/1/0", busy, init_wf_write, err_start);
    end
    wf_write_ready = 1'b1;
    @(negedge clk);
    wf_write_ready = 1'b0;
    collect(4, 0, 50, 0, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 4 || bd !== 0 || bl !== 0 || dk !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got beats=%0d bd=%0d bl=%0d done=%b expected 4/0/0/1", beats, bd, bl, dk);
    end
    $display("[TB] back-to-back: second load %0d beats", beats);
  endtask

  task automatic test_reset_mid();
    int beats, bd, bl, us, sa, es;
    bit dk;
    launch(32'd32, 32'd6, 32'h200, 0);
    collect(32, 0, 100, 5, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 5 || bd !== 0) begin
      fails++; $display("FAIL rst_pre: got beats=%0d bd=%0d expected 5/0", beats, bd);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({wfin_axis_tvalid, wfin_axis_tlast, src_axis_tready, busy, init_wf_write} !== 5'b0 ||
        wfin_axis_tkeep !== 4'h0 || wfin_axis_tdata !== 32'h0 || waveform_parameters !== 128'h0) begin
      fails++; $display("FAIL rst_async: got valid=%b keep=%h data=%h busy=%b params=%h expected all 0",
                        wfin_axis_tvalid, wfin_axis_tkeep, wfin_axis_tdata, busy, waveform_parameters);
    end
    @(negedge clk);
    reset = 1'b0;
    launch(32'd32, 32'd7, 32'h300, 0);
    collect(32, 0, 100, 0, -1, beats, bd, bl, us, sa, es, dk);
    tests++;
    if (beats !== 32 || sa !== 32 || bd !== 0 || bl !== 0 || dk !== 1'b1) begin
      fails++; $display("FAIL rst_fresh: got beats=%0d src=%0d bd=%0d bl=%0d done=%b expected 32/32/0/0/1",
                        beats, sa, bd, bl, dk);
    end
    $display("[TB] reset mid-stream: fresh stream %0d beats", beats);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_rejected();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
